hwpf_fifo: RTL and testbench



---
 rtl/hwpf_fifo.sv | 133 +++++++++++++
 tb/tb_hwpf_fifo.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hwpf_fifo.sv
// hwpf_fifo: ordered queue of next-line prefetch candidates; entry 0 is the head presented to the dcache arbiter.
// Optional HWPF_FIFO_DEDUP_EN: a push that hits a queued line drops the stale copy and re-queues at the tail.

package hwpf_fifo_pkg;
  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [31:0] data_rs1;
    logic [31:0] data_rs2;
  } req_cpu_dcache_t;
endpackage

module hwpf_fifo
  import hwpf_fifo_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int LINE_BYTES = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            lock_i,
  input  logic            take_req_i,
  input  req_cpu_dcache_t cpu_req_i,
  input  logic            read_i,
  output logic            arbiter_req_valid_o,
  output req_cpu_dcache_t arbiter_req_o,
  output logic            req_hits_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_cpu_dcache_t entries      [DEPTH];
  req_cpu_dcache_t after_pop    [DEPTH];
  req_cpu_dcache_t after_rm     [DEPTH];
  req_cpu_dcache_t entries_next [DEPTH];
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_pop;
  logic [CW-1:0]   count_rm;
  logic [CW-1:0]   count_next;
  logic            pop;
  logic            push;
  logic            rm_en;
  logic [IW-1:0]   rm_idx;

  // Slots at or beyond count are always zero, so the head reads as zero when empty.
  assign arbiter_req_valid_o = (count != '0) && lock_i;
  assign arbiter_req_o       = entries[0];
  assign pop                 = read_i && arbiter_req_valid_o;
  assign push                = take_req_i && lock_i;

`ifdef HWPF_FIFO_DEDUP_EN
  localparam int KEY_LSB = $clog2(LINE_BYTES);

  logic [DEPTH-1:0] hit_vec;
  logic [IW-1:0]    hit_idx;

  // Line-address match against every occupied slot; the oldest match wins.
  always_comb begin
    hit_vec = '0;
    hit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CW'(i) < count) &&
          ((entries[i].data_rs1 >> KEY_LSB) == (cpu_req_i.data_rs1 >> KEY_LSB))) begin
        hit_vec[i] = 1'b1;
        hit_idx    = IW'(i);
      end
    end
  end

  assign req_hits_o = take_req_i && (hit_vec != '0);
  // A hit on the head that is being popped this cycle has already left the queue.
  assign rm_en      = push && (hit_vec != '0) && !(pop && (hit_idx == '0));
  assign rm_idx     = pop ? (hit_idx - IW'(1)) : hit_idx;
`else
  logic [31:0] unused_line_bytes;

  assign unused_line_bytes = LINE_BYTES;
  assign req_hits_o        = 1'b0;
  assign rm_en             = 1'b0;
  assign rm_idx            = '0;
`endif

  // Next state built in event order: pop, hit removal, then append.
  always_comb begin
    after_pop = entries;
    count_pop = count;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        after_pop[i] = entries[i+1];
      end
      after_pop[DEPTH-1] = '0;
      count_pop          = count - CW'(1);
    end

    after_rm = after_pop;
    count_rm = count_pop;
    if (rm_en) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IW'(i) >= rm_idx) begin
          after_rm[i] = after_pop[i+1];
        end
      end
      after_rm[DEPTH-1] = '0;
      count_rm          = count_pop - CW'(1);
    end

    entries_next = after_rm;
    count_next   = count_rm;
    if (push && (count_rm < CW'(DEPTH))) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == count_rm) begin
          entries_next[i] = cpu_req_i;
        end
      end
      count_next = count_rm + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni || flush_i) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      count   <= count_next;
      entries <= entries_next;
    end
  end

endmodule

// File: tb/tb_hwpf_fifo.sv
// tb_hwpf_fifo: scoreboard bench for hwpf_fifo; expected queue contents tracked in a SystemVerilog queue.
// Dedup expectations follow HWPF_FIFO_DEDUP_EN, matching the build of the DUT.

module tb_hwpf_fifo;
  import hwpf_fifo_pkg::*;

  localparam int DEPTH      = 8;
  localparam int LINE_BYTES = 64;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            lock;
  logic            take;
  req_cpu_dcache_t cpuReq;
  logic            read;
  logic            arbValid;
  req_cpu_dcache_t arbReq;
  logic            reqHits;

  req_cpu_dcache_t expQ[$];
  int              compareCount  = 0;
  int              mismatchCount = 0;

  hwpf_fifo #(.DEPTH(DEPTH), .LINE_BYTES(LINE_BYTES)) dut (
    .clk_i              (clk),
    .rst_ni             (rst),
    .flush_i            (flush),
    .lock_i             (lock),
    .take_req_i         (take),
    .cpu_req_i          (cpuReq),
    .read_i             (read),
    .arbiter_req_valid_o(arbValid),
    .arbiter_req_o      (arbReq),
    .req_hits_o         (reqHits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic req_cpu_dcache_t mkReq(input int rd, input logic [31:0] addr);
    req_cpu_dcache_t r;
    r.op       = 4'h2;
    r.rd       = 5'(rd);
    r.data_rs1 = addr;
    r.data_rs2 = 32'hD00D_0000 | 32'(rd);
    return r;
  endfunction

  function automatic bit sameLine(input logic [31:0] a, input logic [31:0] b);
    return (a / LINE_BYTES) == (b / LINE_BYTES);
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One clock of stimulus: drive at negedge, compare outputs against the scoreboard, then advance it.
  task automatic applyStimulus(input string tag, input logic r, input logic fl, input logic lk,
                               input logic tk, input req_cpu_dcache_t rq, input logic rd);
    bit              expHit;
    bit              doPop;
    req_cpu_dcache_t expHead;
    @(negedge clk);
    rst    = r;
    flush  = fl;
    lock   = lk;
    take   = tk;
    cpuReq = rq;
    read   = rd;
    #1;
    expHit = 1'b0;
`ifdef HWPF_FIFO_DEDUP_EN
    foreach (expQ[i]) if (sameLine(expQ[i].data_rs1, rq.data_rs1)) expHit = tk;
`endif
    expHead = (expQ.size() > 0) ? expQ[0] : '0;
    checkOutput({tag, ":valid"}, 128'(arbValid), 128'(lk && (expQ.size() > 0)));
    checkOutput({tag, ":head"}, 128'(arbReq), 128'(expHead));
    checkOutput({tag, ":hits"}, 128'(reqHits), 128'(expHit));

    if (r || fl) begin
      expQ.delete();
    end else begin
      doPop = rd && lk && (expQ.size() > 0);
      if (doPop) void'(expQ.pop_front());
      if (tk && lk) begin
`ifdef HWPF_FIFO_DEDUP_EN
        for (int i = 0; i < expQ.size(); i++) begin
          if (sameLine(expQ[i].data_rs1, rq.data_rs1)) begin
            expQ.delete(i);
            break;
          end
        end
`endif
        if (expQ.size() < DEPTH) expQ.push_back(rq);
      end
    end
  endtask

  task automatic idle(input string tag, input logic rd);
    applyStimulus(tag, 1'b0, 1'b0, 1'b1, 1'b0, '0, rd);
  endtask

  task automatic pushReq(input string tag, input int rdv, input logic [31:0] addr, input logic rd);
    applyStimulus(tag, 1'b0, 1'b0, 1'b1, 1'b1, mkReq(rdv, addr), rd);
  endtask

  initial begin
    rst    = 1'b1;
    flush  = 1'b0;
    lock   = 1'b1;
    take   = 1'b0;
    cpuReq = '0;
    read   = 1'b1;
    @(posedge clk);
    // Held reset with an empty queue and an eager arbiter.
    applyStimulus("reset", 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    applyStimulus("reset", 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    idle("empty", 1'b1);

    pushReq("single_push", 1, 32'hCAFE_CAFE, 1'b0);
    idle("single_pop", 1'b1);
    idle("single_after", 1'b1);

    // Concurrent push and pop with one entry resident.
    pushReq("pp_fill", 2, 32'h0001_BEC0, 1'b0);
    pushReq("pp_both", 3, 32'hC0DE_1100, 1'b1);
    idle("pp_next", 1'b1);
    idle("pp_empty", 1'b0);

    // Overfill: entries 8 and 9 must be dropped.
    for (int i = 0; i < 10; i++) pushReq("overfill", i, 32'(i * 64), 1'b0);
    for (int i = 0; i < 10; i++) idle("drain", 1'b1);

    // Full queue with a push and pop each cycle keeps occupancy at DEPTH.
    for (int i = 0; i < DEPTH; i++) pushReq("refill", 16 + i, 32'h4000 + 32'(i * 64), 1'b0);
    for (int i = 0; i < 4; i++) pushReq("full_pp", 24 + i, 32'h8000 + 32'(i * 64), 1'b1);
    applyStimulus("flush", 1'b0, 1'b1, 1'b1, 1'b1, mkReq(5, 32'h9000), 1'b1);
    pushReq("post_flush", 6, 32'h9040, 1'b0);
    idle("post_flush_pop", 1'b1);
    idle("post_flush_empty", 1'b0);

    // Same-line re-request: A, B, then C on A's line.
    pushReq("dedup_a", 10, 32'h0000_1000, 1'b0);
    pushReq("dedup_b", 11, 32'h0000_2000, 1'b0);
    pushReq("dedup_c", 12, 32'h0000_1000, 1'b0);
    for (int i = 0; i < 4; i++) idle("dedup_drain", 1'b1);

    // Frozen queue ignores pushes and reads.
    pushReq("lock_fill", 13, 32'h0000_3000, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus("locked", 1'b0, 1'b0, 1'b0, 1'b1, mkReq(14 + i, 32'h0000_3000 + 32'(i * 64)), 1'b1);
    idle("unlocked", 1'b1);
    idle("unlocked_empty", 1'b1);

    // Random traffic over a small set of lines so hits, full and empty cases recur.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] addr;
      addr = 32'($urandom_range(0, 11) * 64 + $urandom_range(0, 63));
      applyStimulus("random",
                    1'b0,
                    ($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 9) < 6),
                    mkReq($urandom_range(0, 31), addr),
                    ($urandom_range(0, 9) < 5));
    end

    // Reset mid-operation discards contents.
    for (int i = 0; i < 3; i++) pushReq("pre_reset", 20 + i, 32'h0000_5000 + 32'(i * 64), 1'b0);
    applyStimulus("mid_reset", 1'b1, 1'b0, 1'b1, 1'b1, mkReq(7, 32'h6000), 1'b0);
    idle("after_reset", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
